fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the pipelined MIPS core. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, buffers returned words in a small prefetch queue, and presents `InstrF`/`PcPlus4f` to the IF/ID pipeline register. It honours the same stall signal that holds the IF/ID register and accepts branch/jump redirects from Decode.

## Interface

Parameters:
- `DEPTH`, 2: prefetch queue entries (power of two, ≥2).
- `RESET_PC`, 32'h0000_0000: PC after reset.

Ports:
- `CLK` in 1: single clock; all state on rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `StallF` in 1: 1 = IF/ID is holding; head entry must not be consumed.
- `PCSrcD` in 1: redirect request from Decode.
- `PcBranchD` in 32: redirect target, valid when `PCSrcD`=1.
- `ImemReq` out 1: read request to instruction memory.
- `ImemAddr` out 32: word-aligned read address.
- `ImemAck` in 1: read complete; `ImemRdata` valid this cycle.
- `ImemRdata` in 32: instruction word.
- `InstrF` out 32: instruction to IF/ID (0 = nop when invalid).
- `PcPlus4f` out 32: address of `InstrF` plus 4 (0 when invalid).
- `ValidF` out 1: `InstrF`/`PcPlus4f` carry a real instruction.

## Operation

- Registers: `FetchPc` (next address to fetch), `ReqAddr` (drives `ImemAddr`), FSM state, queue of {instr, pc+4}.
- Queue head drives `InstrF`, `PcPlus4f`; `ValidF` = queue non-empty. Pop when `ValidF` & !`StallF` & !`PCSrcD`.
- At most one outstanding request. Once `ImemReq` rises, `ImemReq` and `ImemAddr` stay stable until `ImemAck`.
- A request starts only when queue count < `DEPTH` after the current cycle's pop; space at ack is therefore guaranteed.
- FSM states:
  - IDLE (`ImemReq`=0): queue not full → REQ, `ReqAddr`←`FetchPc`.
  - REQ (`ImemReq`=1): `ImemAck` & !`PCSrcD` → push {`ImemRdata`, `ReqAddr`+4}, `FetchPc`←`ReqAddr`+4; stay REQ with `ReqAddr`←`ReqAddr`+4 if space remains, else IDLE. `ImemAck` & `PCSrcD` → discard data, REQ with `ReqAddr`←`PcBranchD`. !`ImemAck` & `PCSrcD` → STALE.
  - STALE (`ImemReq`=1, old address held): on `ImemAck` discard data → REQ with `ReqAddr`←`FetchPc`.
- Redirect (any state): queue cleared, `FetchPc`←`PcBranchD`. Redirect beats push and pop in the same cycle. A redirect while in STALE only updates `FetchPc`.
- `PcPlus4f` arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- The queue wraps with `log2(DEPTH)`-bit pointers plus a count. Simultaneous push and pop leaves the count unchanged.

## Timing

- Reset values: state IDLE, `FetchPc`=`ReqAddr`=`RESET_PC`, queue empty, `ImemReq`=0, `ImemAddr`=`RESET_PC`, `InstrF`=0, `PcPlus4f`=0, `ValidF`=0.
- First cycle after reset release: IDLE→REQ; `ImemReq`=1 on the following cycle.
- Zero-wait memory (ack in the same cycle as req): one fetch per cycle sustained.
- Ack-to-`ValidF` latency: 1 cycle (pushed at edge).
- Redirect at cycle N: `ValidF`=0 at N+1. The new request is visible at N+1 (IDLE/REQ-with-ack) or after the stale ack.
- Reset mid-request abandons the transaction. Memory must tolerate a dropped req.

## Configuration

- `FETCH_BYPASS_EN` defined: in REQ, when `ImemAck` & queue empty & !`StallF` & !`PCSrcD`, `ImemRdata` and `ReqAddr`+4 drive `InstrF`/`PcPlus4f` with `ValidF`=1 in the same cycle, and no push occurs. Ack-to-valid latency is 0.
- Not defined: all returned data passes through the queue; latency is 1.

## Structure

- Package `mips_fetch_pkg` holds:
  - the `RESET_PC` default,
  - the FSM state encoding (IDLE/REQ/STALE),
  - the queue entry type {instr[31:0], pcplus4[31:0]},
  - the constant `NOP_INSTR`=0.
- Sub-module `fetch_queue`: synchronous FIFO with parameterised `DEPTH`, push, pop, clear (clear has priority), head, count, full, and empty.
- `fetch_unit` contains the FSM, PC registers, and output muxing.

## Test plan

- Reset, zero-wait memory returning `ImemRdata`=addr^32'hA5A5_0000, no stall → `ImemAddr` sequence 0,4,8,…; `InstrF` 32'hA5A5_0000 with `PcPlus4f`=4 appears first, then one valid instruction per cycle.
- `ImemAck` delayed 3 cycles → `ImemReq`/`ImemAddr` stable across the wait; `ValidF` rises 1 cycle after ack (0 cycles with `FETCH_BYPASS_EN`).
- `StallF` held 5 cycles → queue fills to `DEPTH`, FSM goes IDLE with `ImemReq`=0, and `InstrF` holds. After release, entries drain in order with no loss or duplication.
- `PCSrcD`=1, `PcBranchD`=32'h0000_0100 while a request to 8 is pending unacked → STALE, and the ack data is dropped. The next request is to 0x100, and the first valid output has `PcPlus4f`=0x104.
- Redirect in the same cycle as ack and pop → queue empty next cycle, `ValidF`=0, `ImemAddr`=`PcBranchD`.
- `RESET_PC`=32'hFFFF_FFFC → first `PcPlus4f`=0 and the next `ImemAddr`=0. Asserting `Reset` low mid-request forces `ImemReq`=0 immediately.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared types and constants for the instruction-fetch stage.
package mips_fetch_pkg;

    // PC loaded by reset unless the instance overrides it
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction presented to IF/ID when nothing valid is available
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Fetch FSM: idle, request outstanding, request outstanding but redirected
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_STALE = 2'd2
    } fetch_state_t;

    // One prefetched instruction and the sequential address after it
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
    } fq_entry_t;

    // Sequential successor, 32-bit modulo so the top word wraps to 0
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry prefetch FIFO of {instr, pc+4}. Clear wins over
// push and pop; a push into a full queue is accepted only alongside a pop.
module fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [31:0]              push_instr,
    input  logic [31:0]              push_pc4,
    input  logic                     pop,
    output logic [31:0]              head_instr,
    output logic [31:0]              head_pc4,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t     mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = cnt;

    assign head_instr = mem[rd_ptr].instr;
    assign head_pc4   = mem[rd_ptr].pcplus4;

    // pointers wrap naturally at DEPTH; count tracks occupancy
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // storage has no reset: head is only observed when the queue is non-empty
    always_ff @(posedge CLK) begin
        if (do_push && !clear) mem[wr_ptr] <= {push_instr, push_pc4};
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage. Owns the PC, runs one outstanding req/ack read to
// instruction memory, buffers words in fetch_queue and feeds IF/ID.
// Optional FETCH_BYPASS_EN: returned data goes straight to InstrF when the
// queue is empty and IF/ID is accepting, saving one cycle of latency.
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PcBranchD,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRdata,
    output logic [31:0] InstrF,
    output logic [31:0] PcPlus4f,
    output logic        ValidF
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;
    logic [31:0]   req_pc4;

    logic [CW-1:0] q_count;
    logic [CW-1:0] cnt_after_pop;
    logic          q_full;
    logic          q_empty;
    logic [31:0]   head_instr;
    logic [31:0]   head_pc4;

    logic          ack;
    logic          pop;
    logic          push;
    logic          bypass;
    logic          room_after_ack;

    assign req_pc4 = pc_plus4(req_addr);
    assign ack     = (state == S_REQ) && ImemAck;

    // a redirect squashes the head, so it is never consumed that cycle
    assign pop = !q_empty && !StallF && !PCSrcD;

`ifdef FETCH_BYPASS_EN
    assign bypass = ack && q_empty && !StallF && !PCSrcD;
`else
    assign bypass = 1'b0;
`endif

    assign push          = ack && !PCSrcD && !bypass;
    assign cnt_after_pop = q_count - CW'(pop);

    // a new request may only follow if this cycle's return still leaves a slot,
    // which is what guarantees space for the data when its ack arrives
    assign room_after_ack = (cnt_after_pop + CW'(push)) < CW'(DEPTH);

    assign ImemReq  = (state != S_IDLE);
    assign ImemAddr = req_addr;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .CLK        (CLK),
        .Reset      (Reset),
        .clear      (PCSrcD),
        .push       (push),
        .push_instr (ImemRdata),
        .push_pc4   (req_pc4),
        .pop        (pop),
        .head_instr (head_instr),
        .head_pc4   (head_pc4),
        .count      (q_count),
        .full       (q_full),
        .empty      (q_empty)
    );

    // request FSM with the fetch and request address registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (PCSrcD) begin
                        fetch_pc <= PcBranchD;
                        req_addr <= PcBranchD;
                        state    <= S_REQ;
                    end else if (cnt_after_pop < CW'(DEPTH)) begin
                        req_addr <= fetch_pc;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (PCSrcD) begin
                        fetch_pc <= PcBranchD;
                        // without the ack the bus still owns the old address
                        if (ImemAck) req_addr <= PcBranchD;
                        else         state    <= S_STALE;
                    end else if (ImemAck) begin
                        fetch_pc <= req_pc4;
                        if (room_after_ack) req_addr <= req_pc4;
                        else                state    <= S_IDLE;
                    end
                end
                S_STALE: begin
                    if (PCSrcD) fetch_pc <= PcBranchD;
                    // stale data is dropped; restart at the newest target
                    if (ImemAck) begin
                        req_addr <= PCSrcD ? PcBranchD : fetch_pc;
                        state    <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // IF/ID view: queue head, or the returning word when bypassing
    always_comb begin
        ValidF   = !q_empty;
        InstrF   = q_empty ? NOP_INSTR : head_instr;
        PcPlus4f = q_empty ? 32'h0 : head_pc4;
        if (bypass) begin
            ValidF   = 1'b1;
            InstrF   = ImemRdata;
            PcPlus4f = req_pc4;
        end
    end

    // the request gate must never let returning data overflow the queue
    a_no_overflow: assert property (@(posedge CLK) disable iff (!Reset)
        push |-> (!q_full || pop));

endmodule
